// File: rtl/mem_pkg.sv
// Shared definitions for the mem initiator front end.
// Mode encodings match the mem block's mode pin.
package mem_pkg;

    localparam logic MEM_MODE_WRITE = 1'b0;
    localparam logic MEM_MODE_READ  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } mem_req_state_t;

    function automatic logic mode_for(input logic write);
        return write ? MEM_MODE_WRITE : MEM_MODE_READ;
    endfunction

endpackage

// File: rtl/mem_requester.sv
// Initiator front end for mem: one request at a time,
// holds mem lines for LAT cycles, returns a response.
module mem_requester
    import mem_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    mem_req_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic             wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            wr_q        <= 1'b0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            mem_mode    <= MEM_MODE_READ;
            mem_address <= '0;
            mem_data_in <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_ready && req_valid) begin
                        state       <= ACCESS;
                        req_ready   <= 1'b0;
                        cnt         <= CNT_LOAD;
                        wr_q        <= req_write;
                        mem_mode    <= mode_for(req_write);
                        mem_address <= req_addr;
                        mem_data_in <= req_wdata;
                    end else begin
                        // ready comes up one cycle after reset release
                        req_ready <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state     <= RESP;
                        mem_mode  <= MEM_MODE_READ;
                        rsp_valid <= 1'b1;
                        rsp_write <= wr_q;
                        rsp_rdata <= wr_q ? '0 : mem_data_out;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    mem_mode  <= MEM_MODE_READ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: LAT=1 and LAT=3 instances,
// each backed by a behavioural mem array.
module tb_mem_requester;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        r1_valid = 0, r1_write = 0, s1_ready = 1;
    logic [63:0] r1_addr = 0, r1_wdata = 0;
    logic        r1_ready, s1_valid, s1_write, m1_mode;
    logic [63:0] s1_rdata, m1_addr, m1_din, m1_dout;

    logic        r3_valid = 0, r3_write = 0, s3_ready = 1;
    logic [63:0] r3_addr = 0, r3_wdata = 0;
    logic        r3_ready, s3_valid, s3_write, m3_mode;
    logic [63:0] s3_rdata, m3_addr, m3_din, m3_dout;

    logic [63:0] mem1 [0:255] = '{default: '0};
    logic [63:0] mem3 [0:255] = '{default: '0};
    logic [63:0] ref_mem [0:255] = '{default: '0};

    int n_cmp = 0;
    int n_bad = 0;

    mem_requester #(.ADDR_W(64), .DATA_W(64), .LAT(1)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(r1_valid), .req_ready(r1_ready),
        .req_write(r1_write), .req_addr(r1_addr), .req_wdata(r1_wdata),
        .rsp_valid(s1_valid), .rsp_ready(s1_ready),
        .rsp_write(s1_write), .rsp_rdata(s1_rdata),
        .mem_mode(m1_mode), .mem_address(m1_addr),
        .mem_data_in(m1_din), .mem_data_out(m1_dout)
    );

    mem_requester #(.ADDR_W(64), .DATA_W(64), .LAT(3)) u3 (
        .clk(clk), .rst(rst),
        .req_valid(r3_valid), .req_ready(r3_ready),
        .req_write(r3_write), .req_addr(r3_addr), .req_wdata(r3_wdata),
        .rsp_valid(s3_valid), .rsp_ready(s3_ready),
        .rsp_write(s3_write), .rsp_rdata(s3_rdata),
        .mem_mode(m3_mode), .mem_address(m3_addr),
        .mem_data_in(m3_din), .mem_data_out(m3_dout)
    );

    // mem block: write on clock while mode=0, read combinational
    assign m1_dout = mem1[m1_addr[7:0]];
    assign m3_dout = mem3[m3_addr[7:0]];
    always @(posedge clk) begin
        if (m1_mode == 1'b0) mem1[m1_addr[7:0]] <= m1_din;
        if (m3_mode == 1'b0) mem3[m3_addr[7:0]] <= m3_din;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        n_cmp++;
        if ({s1_valid, s1_write, s1_rdata, m1_mode, m1_addr, m1_din, r1_ready}
            !== {1'b0, 1'b0, 64'd0, 1'b1, 64'd0, 64'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_u1 got v=%b w=%b d=%h m=%b a=%h i=%h r=%b exp 0 0 0 1 0 0 0",
                     s1_valid, s1_write, s1_rdata, m1_mode, m1_addr, m1_din, r1_ready);
        end
        n_cmp++;
        if ({s3_valid, m3_mode, r3_ready} !== 3'b010) begin
            n_bad++;
            $display("FAIL reset_u3 got v=%b m=%b r=%b exp 0 1 0",
                     s3_valid, m3_mode, r3_ready);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if ({r1_ready, r3_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_release_ready got %b%b exp 11", r1_ready, r3_ready);
        end
    endtask

    task automatic test_write();
        r1_valid = 1; r1_write = 1; r1_addr = 0; r1_wdata = 64'd2017;
        s1_ready = 1;
        step();
        r1_valid = 0;
        ref_mem[0] = 64'd2017;
        n_cmp++;
        if ({m1_mode, m1_addr, m1_din, r1_ready, s1_valid}
            !== {1'b0, 64'd0, 64'd2017, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL write_access got m=%b a=%h i=%h r=%b v=%b exp 0 0 7e1 0 0",
                     m1_mode, m1_addr, m1_din, r1_ready, s1_valid);
        end
        step();
        n_cmp++;
        if ({m1_mode, s1_valid, s1_write, s1_rdata, r1_ready}
            !== {1'b1, 1'b1, 1'b1, 64'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL write_resp got m=%b v=%b w=%b d=%h r=%b exp 1 1 1 0 0",
                     m1_mode, s1_valid, s1_write, s1_rdata, r1_ready);
        end
        step();
        n_cmp++;
        if ({s1_valid, r1_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL write_idle got v=%b r=%b exp 0 1", s1_valid, r1_ready);
        end
    endtask

    task automatic test_read();
        r1_valid = 1; r1_write = 0; r1_addr = 0; r1_wdata = 64'hFFFF;
        step();
        r1_valid = 0;
        n_cmp++;
        if ({m1_mode, m1_addr, s1_valid} !== {1'b1, 64'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL read_access got m=%b a=%h v=%b exp 1 0 0",
                     m1_mode, m1_addr, s1_valid);
        end
        step();
        n_cmp++;
        if ({s1_valid, s1_write, s1_rdata} !== {1'b1, 1'b0, 64'h7E1}) begin
            n_bad++;
            $display("FAIL read_resp got v=%b w=%b d=%h exp 1 0 7e1",
                     s1_valid, s1_write, s1_rdata);
        end
        step();
    endtask

    task automatic test_backpressure();
        s1_ready = 0;
        r1_valid = 1; r1_write = 0; r1_addr = 0;
        step();
        r1_valid = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({s1_valid, s1_rdata, r1_ready} !== {1'b1, ref_mem[0], 1'b0}) begin
                n_bad++;
                $display("FAIL backpressure_hold cyc %0d got v=%b d=%h r=%b exp 1 %h 0",
                         i, s1_valid, s1_rdata, r1_ready, ref_mem[0]);
            end
            step();
        end
        s1_ready = 1;
        step();
        n_cmp++;
        if ({s1_valid, r1_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL backpressure_release got v=%b r=%b exp 0 1",
                     s1_valid, r1_ready);
        end
    endtask

    task automatic test_lat3();
        r3_valid = 1; r3_write = 1; r3_addr = 8; r3_wdata = 64'hDEAD;
        s3_ready = 1;
        step();
        r3_valid = 0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({m3_mode, m3_addr, m3_din, s3_valid}
                !== {1'b0, 64'd8, 64'hDEAD, 1'b0}) begin
                n_bad++;
                $display("FAIL lat3_write_hold cyc %0d got m=%b a=%h i=%h v=%b exp 0 8 dead 0",
                         i, m3_mode, m3_addr, m3_din, s3_valid);
            end
            step();
        end
        n_cmp++;
        if ({m3_mode, s3_valid, s3_write, s3_rdata} !== {1'b1, 1'b1, 1'b1, 64'd0}) begin
            n_bad++;
            $display("FAIL lat3_write_resp got m=%b v=%b w=%b d=%h exp 1 1 1 0",
                     m3_mode, s3_valid, s3_write, s3_rdata);
        end
        step();
        r3_valid = 1; r3_write = 0; r3_addr = 8;
        step();
        r3_valid = 0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({m3_mode, m3_addr, s3_valid} !== {1'b1, 64'd8, 1'b0}) begin
                n_bad++;
                $display("FAIL lat3_read_hold cyc %0d got m=%b a=%h v=%b exp 1 8 0",
                         i, m3_mode, m3_addr, s3_valid);
            end
            step();
        end
        n_cmp++;
        if ({m3_mode, s3_valid, s3_write, s3_rdata} !== {1'b1, 1'b1, 1'b0, 64'hDEAD}) begin
            n_bad++;
            $display("FAIL lat3_read_resp got m=%b v=%b w=%b d=%h exp 1 1 0 dead",
                     m3_mode, s3_valid, s3_write, s3_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid_access();
        r1_valid = 1; r1_write = 1; r1_addr = 200; r1_wdata = 64'h1234;
        step();
        r1_valid = 0;
        n_cmp++;
        if (m1_mode !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_in_access got m=%b exp 0", m1_mode);
        end
        rst = 1;
        step();
        n_cmp++;
        if ({m1_mode, m1_addr, s1_valid, r1_ready} !== {1'b1, 64'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL abort_reset got m=%b a=%h v=%b r=%b exp 1 0 0 0",
                     m1_mode, m1_addr, s1_valid, r1_ready);
        end
        rst = 0;
        step();
        n_cmp++;
        if (r1_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_ready got %b exp 1", r1_ready);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (s1_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_no_rsp cyc %0d got v=%b exp 0", i, s1_valid);
            end
            step();
        end
    endtask

    task automatic test_back_to_back(input int n, input bit bp);
        bit          exp_w[$];
        logic [63:0] exp_d[$];
        int          acc = 0;
        int          last = -1;
        int          cyc = 0;
        bit          take;
        bit          hold_v = 0;
        logic [64:0] hold;
        logic [63:0] a;
        r1_valid = 1;
        r1_write = 1'($urandom);
        r1_addr  = 64'($urandom_range(0, 63));
        r1_wdata = {$urandom, $urandom};
        s1_ready = 1;
        while ((acc < n || exp_w.size() != 0) && cyc < 400) begin
            if (s1_valid) begin
                if (hold_v) begin
                    n_cmp++;
                    if ({s1_write, s1_rdata} !== hold) begin
                        n_bad++;
                        $display("FAIL rsp_stable got %h exp %h", {s1_write, s1_rdata}, hold);
                    end
                end
                if (s1_ready) begin
                    hold_v = 0;
                    n_cmp++;
                    if (exp_w.size() == 0) begin
                        n_bad++;
                        $display("FAIL rsp_unexpected got w=%b d=%h exp none",
                                 s1_write, s1_rdata);
                    end else if ({s1_write, s1_rdata} !== {exp_w[0], exp_d[0]}) begin
                        n_bad++;
                        $display("FAIL rsp_order got w=%b d=%h exp w=%b d=%h",
                                 s1_write, s1_rdata, exp_w[0], exp_d[0]);
                    end
                    if (exp_w.size() != 0) begin
                        void'(exp_w.pop_front());
                        void'(exp_d.pop_front());
                    end
                end else begin
                    hold_v = 1;
                    hold = {s1_write, s1_rdata};
                end
            end
            take = r1_valid && r1_ready;
            if (take) begin
                if (!bp && last >= 0) begin
                    n_cmp++;
                    if (cyc - last != 3) begin
                        n_bad++;
                        $display("FAIL accept_period got %0d exp 3", cyc - last);
                    end
                end
                last = cyc;
                acc++;
                a = r1_addr;
                if (r1_write) begin
                    ref_mem[a[7:0]] = r1_wdata;
                    exp_w.push_back(1'b1);
                    exp_d.push_back(64'd0);
                end else begin
                    exp_w.push_back(1'b0);
                    exp_d.push_back(ref_mem[a[7:0]]);
                end
            end
            step();
            cyc++;
            if (take) begin
                if (acc < n) begin
                    r1_write = 1'($urandom);
                    r1_addr  = 64'($urandom_range(0, 63));
                    r1_wdata = {$urandom, $urandom};
                end else begin
                    r1_valid = 0;
                end
            end
            if (bp) s1_ready = 1'($urandom);
        end
        n_cmp++;
        if (acc < n || exp_w.size() != 0) begin
            n_bad++;
            $display("FAIL traffic_timeout got acc=%0d pending=%0d exp acc=%0d pending=0",
                     acc, exp_w.size(), n);
        end
        r1_valid = 0;
        s1_ready = 1;
        repeat (3) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_lat3();
        test_reset_mid_access();
        test_back_to_back(12, 1'b0);
        test_back_to_back(30, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
